keypad_matrix_scanner: RTL and testbench

//  Input-side counterpart of the 8x8 LED scan driver. It drives keypad columns one at a time
//  (active-low) and reads the row lines back. Each key is debounced, and debounced key events
//  are queued in a small FIFO for game logic through a valid/ready port.

---
 rtl/keypad_pkg.sv | 35 +++
 rtl/keypad_event_fifo.sv | 57 +++++
 rtl/keypad_matrix_scanner.sv | 187 ++++++++++++++++++
 tb/tb_keypad_matrix_scanner.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and sizing helpers for the keypad scanner; event entry layout is
// {release flag (only with KEYPAD_RELEASE_EVT_EN), key code}, flag in the MSB.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SAMPLE,
    ST_EVAL,
    ST_NEXT
  } scan_state_e;

`ifdef KEYPAD_RELEASE_EVT_EN
  localparam bit REL_EVT_EN = 1'b1;
`else
  localparam bit REL_EVT_EN = 1'b0;
`endif

  // Index width that stays >= 1 even for tiny counts.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int key_w(input int rows, input int cols);
    return clog2_min1(rows * cols);
  endfunction

  function automatic int dwell_cycles(input int clk_hz, input int scan_hz);
    return clk_hz / scan_hz;
  endfunction

  function automatic int ev_w(input int kw);
    return kw + (REL_EVT_EN ? 1 : 0);
  endfunction

endpackage

// File: rtl/keypad_event_fifo.sv
// Key event queue: registered head, data visible the cycle after push into an empty queue.
// Push into a full queue without a same-cycle pop is dropped and flagged on drop.
module keypad_event_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic             empty,
  output logic             full,
  output logic             drop
);

  localparam int AW = (DEPTH <= 2) ? 1 : $clog2(DEPTH);

  logic [AW:0]                  wr_ptr_q, wr_ptr_d;
  logic [AW:0]                  rd_ptr_q, rd_ptr_d;
  logic [DEPTH-1:0][WIDTH-1:0]  mem_q, mem_d;
  logic                         do_push, do_pop;

  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_pop   = pop && !empty;
    // A pop frees the head slot in the same cycle, so full+push+pop still accepts.
    do_push  = push && (!full || do_pop);
    drop     = push && !do_push;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_dat;
      wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
    head_dat = mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      mem_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/keypad_matrix_scanner.sv
// Column-strobed keypad scanner with per-key debounce and a valid/ready event queue.
// Event visible the cycle after its EVAL cycle; KEYPAD_RELEASE_EVT_EN also queues release events.
module keypad_matrix_scanner
  import keypad_pkg::*;
#(
  parameter int CLK_HZ         = 50_000_000,
  parameter int SCAN_HZ        = 1000,
  parameter int ROWS           = 4,
  parameter int COLS           = 4,
  parameter int DEBOUNCE_SCANS = 8,
  parameter int FIFO_DEPTH     = 4,
  localparam int KEY_W         = key_w(ROWS, COLS)
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  output logic [COLS-1:0]      col_drive,
  input  logic [ROWS-1:0]      row_sense,
  output logic                 key_valid,
  input  logic                 key_ready,
  output logic [KEY_W-1:0]     key_code,
  output logic                 key_release,
  output logic [ROWS*COLS-1:0] key_state,
  output logic                 overflow
);

  localparam int DWELL = dwell_cycles(CLK_HZ, SCAN_HZ);
  localparam int DW_W  = clog2_min1(DWELL);
  localparam int COL_W = clog2_min1(COLS);
  localparam int ROW_W = clog2_min1(ROWS);
  localparam int CNT_W = clog2_min1(DEBOUNCE_SCANS);
  localparam int NKEY  = ROWS * COLS;
  localparam int EV_W  = ev_w(KEY_W);

  logic                        run_q, run_d;
  logic [DW_W-1:0]             dwell_q, dwell_d;
  logic [COL_W-1:0]            col_q, col_d;
  logic [COLS-1:0]             col_drive_q, col_drive_d;
  logic [ROWS-1:0]             sync1_q, sync1_d, sync2_q, sync2_d;
  logic [ROWS-1:0]             sample_q, sample_d;
  logic [COL_W-1:0]            scol_q, scol_d;
  logic [ROW_W-1:0]            row_q, row_d;
  scan_state_e                 state_q, state_d;
  logic [NKEY-1:0]             key_state_q, key_state_d;
  logic [NKEY-1:0][CNT_W-1:0]  cnt_q, cnt_d;
  logic                        overflow_q, overflow_d;

  logic                        push;
  logic [EV_W-1:0]             push_dat;
  logic [EV_W-1:0]             head_dat;
  logic                        fifo_empty, fifo_full, fifo_drop;
  logic                        raw;
  int                          key_int;
  logic [KEY_W-1:0]            key_idx;

  // run_q holds the dwell counter at 0 for the first cycle out of reset so
  // column 0 gets a full dwell.
  always_comb begin
    run_d   = 1'b1;
    dwell_d = dwell_q;
    col_d   = col_q;
    if (run_q) begin
      if (dwell_q == DW_W'(DWELL - 1)) begin
        dwell_d = '0;
        col_d   = (col_q == COL_W'(COLS - 1)) ? '0 : col_q + COL_W'(1);
      end else begin
        dwell_d = dwell_q + DW_W'(1);
      end
    end
    col_drive_d = ~(COLS'(1) << col_d);
    sync1_d     = row_sense;
    sync2_d     = sync1_q;
    overflow_d  = overflow_q | fifo_drop;
  end

  // EVAL runs on the latched column, so it may spill into the next column's dwell.
  always_comb begin
    state_d     = state_q;
    sample_d    = sample_q;
    scol_d      = scol_q;
    row_d       = row_q;
    key_state_d = key_state_q;
    cnt_d       = cnt_q;
    push        = 1'b0;
    push_dat    = '0;
    raw         = 1'b0;
    key_int     = 0;
    key_idx     = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (run_q && dwell_q == DW_W'(DWELL - 3)) state_d = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        sample_d = sync2_q;
        scol_d   = col_q;
        row_d    = '0;
        state_d  = ST_EVAL;
      end
      ST_EVAL: begin
        key_int = int'(row_q) * COLS + int'(scol_q);
        key_idx = KEY_W'(key_int);
        raw     = ~sample_q[row_q];
        if (raw == key_state_q[key_idx]) begin
          cnt_d[key_idx] = '0;
        end else if (cnt_q[key_idx] == CNT_W'(DEBOUNCE_SCANS - 1)) begin
          cnt_d[key_idx]       = '0;
          key_state_d[key_idx] = raw;
`ifdef KEYPAD_RELEASE_EVT_EN
          push     = 1'b1;
          push_dat = {~raw, key_idx};
`else
          push     = raw;
          push_dat = key_idx;
`endif
        end else begin
          cnt_d[key_idx] = cnt_q[key_idx] + CNT_W'(1);
        end
        if (row_q == ROW_W'(ROWS - 1)) state_d = ST_NEXT;
        else row_d = row_q + ROW_W'(1);
      end
      ST_NEXT: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      run_q       <= 1'b0;
      dwell_q     <= '0;
      col_q       <= '0;
      col_drive_q <= '1;
      sync1_q     <= '1;
      sync2_q     <= '1;
      sample_q    <= '1;
      scol_q      <= '0;
      row_q       <= '0;
      state_q     <= ST_IDLE;
      key_state_q <= '0;
      cnt_q       <= '0;
      overflow_q  <= 1'b0;
    end else begin
      run_q       <= run_d;
      dwell_q     <= dwell_d;
      col_q       <= col_d;
      col_drive_q <= col_drive_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      sample_q    <= sample_d;
      scol_q      <= scol_d;
      row_q       <= row_d;
      state_q     <= state_d;
      key_state_q <= key_state_d;
      cnt_q       <= cnt_d;
      overflow_q  <= overflow_d;
    end
  end

  keypad_event_fifo #(
    .WIDTH (EV_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (CLK),
    .rst_n    (RST_N),
    .push     (push),
    .push_dat (push_dat),
    .pop      (key_valid && key_ready),
    .head_dat (head_dat),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .drop     (fifo_drop)
  );

  assign col_drive = col_drive_q;
  assign key_valid = !fifo_empty;
  assign key_code  = key_valid ? head_dat[KEY_W-1:0] : '0;
`ifdef KEYPAD_RELEASE_EVT_EN
  assign key_release = key_valid & head_dat[KEY_W];
`else
  assign key_release = 1'b0;
`endif
  assign key_state = key_state_q;
  assign overflow  = overflow_q;

  // Full status is implied by the drop pulse; kept on the port list for reuse.
  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Directed bench for keypad_matrix_scanner with DWELL=10, DEBOUNCE_SCANS=3, FIFO_DEPTH=4.
module tb_keypad_matrix_scanner;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [3:0]  col_drive, row_sense;
  logic        key_valid, key_ready, key_release, overflow;
  logic [3:0]  key_code;
  logic [15:0] key_state;
  logic [15:0] press_map = '0;

  int total = 0;
  int bad = 0;
  int now_cyc = 0;

  keypad_matrix_scanner #(
    .CLK_HZ(1000), .SCAN_HZ(100), .ROWS(4), .COLS(4),
    .DEBOUNCE_SCANS(3), .FIFO_DEPTH(4)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .col_drive(col_drive), .row_sense(row_sense),
    .key_valid(key_valid), .key_ready(key_ready), .key_code(key_code),
    .key_release(key_release), .key_state(key_state), .overflow(overflow)
  );

  always #5 CLK = ~CLK;

  // Physical keypad: a pressed key pulls its row low while its column is strobed.
  always_comb begin
    row_sense = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!col_drive[c] && press_map[r*4+c]) row_sense[r] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      now_cyc++;
    end
    #1;
  endtask

  task automatic align(input int m);
    while (now_cyc % m != 0) step(1);
  endtask

  task automatic wait_valid(input int budget, output int waited);
    waited = 0;
    while (!key_valid && waited < budget) begin
      step(1);
      waited++;
    end
  endtask

  // Steps n cycles with whatever key_ready is set, counting cycles with key_valid.
  task automatic run_count(input int n, output int cnt, output logic [3:0] last_code,
                           output logic last_rel);
    cnt = 0;
    last_code = '0;
    last_rel = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (key_valid) begin
        cnt++;
        last_code = key_code;
        last_rel = key_release;
      end
      step(1);
    end
  endtask

  typedef struct {
    int          cyc;
    logic [3:0]  col;
    logic        vld;
    logic [15:0] st;
  } vec_t;

  vec_t tbl[9];
  int   exp_codes[4];

  initial begin
    int w, n;
    logic [3:0] lc;
    logic lr;

    tbl[0] = '{0,  4'b1110, 1'b0, 16'h0};
    tbl[1] = '{9,  4'b1110, 1'b0, 16'h0};
    tbl[2] = '{10, 4'b1101, 1'b0, 16'h0};
    tbl[3] = '{19, 4'b1101, 1'b0, 16'h0};
    tbl[4] = '{20, 4'b1011, 1'b0, 16'h0};
    tbl[5] = '{29, 4'b1011, 1'b0, 16'h0};
    tbl[6] = '{30, 4'b0111, 1'b0, 16'h0};
    tbl[7] = '{39, 4'b0111, 1'b0, 16'h0};
    tbl[8] = '{40, 4'b1110, 1'b0, 16'h0};
    exp_codes = '{0, 4, 8, 12};

    // Reset state
    key_ready = 1'b0;
    RST_N = 1'b0;
    repeat (5) @(posedge CLK);
    #1;
    check("rst_col_drive", col_drive, 4'b1111);
    check("rst_key_valid", key_valid, 0);
    check("rst_key_code", key_code, 0);
    check("rst_key_state", key_state, 0);
    check("rst_overflow", overflow, 0);
    RST_N = 1'b1;
    step(1);
    now_cyc = 0;

    // Column sequence, idle keypad
    for (int i = 0; i < 9; i++) begin
      if (tbl[i].cyc > now_cyc) step(tbl[i].cyc - now_cyc);
      check($sformatf("scan_col_%0d", tbl[i].cyc), col_drive, tbl[i].col);
      check($sformatf("scan_vld_%0d", tbl[i].cyc), key_valid, tbl[i].vld);
      check($sformatf("scan_state_%0d", tbl[i].cyc), key_state, tbl[i].st);
    end
    check("scan_release_bit", key_release, 0);

    // Press r1c2: one event after three frames, none while held
    align(40);
    press_map = 16'h0040;
    wait_valid(200, w);
    check("press_valid", key_valid, 1);
    check("press_latency_window", (w >= 81 && w <= 120), 1);
    check("press_code", key_code, 6);
    check("press_release_bit", key_release, 0);
    check("press_state", key_state, 16'h0040);
    key_ready = 1'b1;
    step(1);
    check("press_popped", key_valid, 0);
    run_count(400, n, lc, lr);
    check("held_no_repeat", n, 0);
    check("held_state", key_state, 16'h0040);

    // Release r1c2
    align(40);
    press_map = 16'h0000;
    run_count(160, n, lc, lr);
`ifdef KEYPAD_RELEASE_EVT_EN
    check("release_events", n, 1);
    check("release_code", lc, 6);
    check("release_flag", lr, 1);
`else
    check("release_events", n, 0);
`endif
    check("release_state", key_state, 0);

    // Bounce: 2 frames pressed, 1 released, three times
    align(40);
    for (int k = 0; k < 3; k++) begin
      press_map = 16'h0040;
      run_count(80, n, lc, lr);
      check($sformatf("bounce_press_%0d", k), n, 0);
      press_map = 16'h0000;
      run_count(40, n, lc, lr);
      check($sformatf("bounce_rel_%0d", k), n, 0);
    end
    check("bounce_state", key_state, 0);

    // Overflow: five keys with consumer stalled
    key_ready = 1'b0;
    align(40);
    press_map = 16'h1113;
    w = 0;
    while (!overflow && w < 200) begin
      step(1);
      w++;
    end
    check("ovf_set", overflow, 1);
    check("ovf_valid", key_valid, 1);
    check("ovf_state", key_state, 16'h1113);
    step(5);
    check("ovf_head_stable", key_code, 0);
    key_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ovf_pop_vld_%0d", i), key_valid, 1);
      check($sformatf("ovf_pop_code_%0d", i), key_code, exp_codes[i]);
      step(1);
    end
    check("ovf_drained", key_valid, 0);
    check("ovf_sticky", overflow, 1);
    press_map = 16'h0000;
    run_count(160, n, lc, lr);
`ifdef KEYPAD_RELEASE_EVT_EN
    check("ovf_release_events", n, 5);
`else
    check("ovf_release_events", n, 0);
`endif
    check("ovf_release_state", key_state, 0);
    check("ovf_still_sticky", overflow, 1);

    // Reset mid-EVAL with an event pending
    key_ready = 1'b0;
    align(40);
    press_map = 16'h0040;
    wait_valid(200, w);
    align(10);
    check("mid_rst_pre_valid", key_valid, 1);
    RST_N = 1'b0;
    step(1);
    check("mid_rst_col_drive", col_drive, 4'b1111);
    check("mid_rst_valid", key_valid, 0);
    check("mid_rst_code", key_code, 0);
    check("mid_rst_state", key_state, 0);
    check("mid_rst_overflow", overflow, 0);
    RST_N = 1'b1;
    step(1);
    now_cyc = 0;
    check("post_rst_col0", col_drive, 4'b1110);
    wait_valid(200, w);
    check("rereport_valid", key_valid, 1);
    check("rereport_window", (w >= 81 && w <= 120), 1);
    check("rereport_code", key_code, 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
